// File: rtl/reaction_timer.sv
// Reaction-time game controller: lamp countdown, random hold-off, then a
// millisecond count of the player's response, saturating at 9999.
module reaction_timer #(
  parameter int TICKS_PER_MS = 50000,
  parameter int LAMP_MS      = 500,
  parameter int NLAMPS       = 10,
  parameter int WAIT_BASE_MS = 1000,
  parameter int WAIT_STEP_MS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              react,
  input  logic [6:0]        rnd,
  output logic [NLAMPS-1:0] ledr,
  output logic [15:0]       time_ms,
  output logic              time_valid,
  output logic              early,
  output logic              busy
);

  localparam int PW   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int LW   = (LAMP_MS > 1) ? $clog2(LAMP_MS) : 1;
  localparam int WMAX = WAIT_BASE_MS + 127 * WAIT_STEP_MS;
  localparam int WW   = ($clog2(WMAX + 1) > 14) ? $clog2(WMAX + 1) : 14;
  localparam logic [15:0] TIME_MAX = 16'd9999;

  typedef enum logic [2:0] {
    S_IDLE, S_LIGHTS, S_WAIT, S_TIMING, S_DONE, S_FALSE
  } state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     presc_reg, presc_next;
  logic [LW-1:0]     lamp_ms_reg, lamp_ms_next;
  logic [WW-1:0]     wait_reg, wait_next;
  logic [NLAMPS-1:0] ledr_reg, ledr_next;
  logic [15:0]       time_reg, time_next;
  logic              valid_reg, valid_next;
  logic              early_reg, early_next;
  logic              busy_reg, busy_next;

  logic              ms_tick;
  logic [15:0]       time_inc;
  logic [WW-1:0]     wait_load;
  logic [NLAMPS-1:0] alt_mask;

  // False-start pattern: every odd lamp lit.
  for (genvar gi = 0; gi < NLAMPS; gi++) begin : g_alt
    assign alt_mask[gi] = ((gi % 2) == 1);
  end

  assign ms_tick   = (presc_reg == PW'(TICKS_PER_MS - 1));
  assign time_inc  = time_reg + 16'd1;
  assign wait_load = WW'(WAIT_BASE_MS) + WW'(rnd) * WW'(WAIT_STEP_MS);

  always_comb begin
    state_next   = state_reg;
    presc_next   = presc_reg;
    lamp_ms_next = lamp_ms_reg;
    wait_next    = wait_reg;
    ledr_next    = ledr_reg;
    time_next    = time_reg;
    valid_next   = 1'b0;
    early_next   = early_reg;
    busy_next    = busy_reg;

    case (state_reg)
      S_IDLE: if (start) state_next = S_LIGHTS;
      S_LIGHTS: begin
        if (react) begin
          state_next = S_FALSE;
        end else if (ms_tick) begin
          if (lamp_ms_reg == LW'(LAMP_MS - 1)) begin
            lamp_ms_next = '0;
            if (ledr_reg[NLAMPS-1]) state_next = S_WAIT;
            else ledr_next = (ledr_reg << 1) | NLAMPS'(1);
          end else begin
            lamp_ms_next = lamp_ms_reg + LW'(1);
          end
        end
      end
      S_WAIT: begin
        if (react) begin
          state_next = S_FALSE;
        end else if (ms_tick) begin
          if (wait_reg <= WW'(1)) state_next = S_TIMING;
          else wait_next = wait_reg - WW'(1);
        end
      end
      S_TIMING: begin
        // A tick in the same cycle as react is counted before stopping.
        if (ms_tick) time_next = time_inc;
        if (react || (ms_tick && time_inc == TIME_MAX)) state_next = S_DONE;
      end
      S_DONE, S_FALSE: if (start) state_next = S_LIGHTS;
      default: state_next = S_IDLE;
    endcase

    // Entry actions; the prescaler restarts so each state begins on a full ms.
    if (state_next != state_reg) begin
      presc_next   = '0;
      lamp_ms_next = '0;
      case (state_next)
        S_LIGHTS: begin
          ledr_next  = NLAMPS'(1);
          time_next  = '0;
          early_next = 1'b0;
        end
        S_WAIT:   wait_next = wait_load;
        S_TIMING: begin
          ledr_next = '0;
          time_next = '0;
        end
        S_DONE: begin
          ledr_next  = '0;
          valid_next = 1'b1;
        end
        S_FALSE: begin
          ledr_next  = alt_mask;
          time_next  = '0;
          early_next = 1'b1;
        end
        default: ledr_next = '0;
      endcase
    end else begin
      presc_next = ms_tick ? '0 : presc_reg + PW'(1);
    end

    busy_next = (state_next == S_LIGHTS) || (state_next == S_WAIT) ||
                (state_next == S_TIMING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      presc_reg   <= '0;
      lamp_ms_reg <= '0;
      wait_reg    <= '0;
      ledr_reg    <= '0;
      time_reg    <= '0;
      valid_reg   <= 1'b0;
      early_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      lamp_ms_reg <= lamp_ms_next;
      wait_reg    <= wait_next;
      ledr_reg    <= ledr_next;
      time_reg    <= time_next;
      valid_reg   <= valid_next;
      early_reg   <= early_next;
      busy_reg    <= busy_next;
    end
  end

  assign ledr       = ledr_reg;
  assign time_ms    = time_reg;
  assign time_valid = valid_reg;
  assign early      = early_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: vector table for a full run, directed
// corner cases, and randomized runs against a timeline-based reference model.
module tb_reaction_timer;

  localparam int TPM  = 4;
  localparam int LMS  = 2;
  localparam int NL   = 10;
  localparam int WB   = 4;
  localparam int WS   = 1;
  localparam int L    = NL * LMS * TPM;   // LIGHTS length in cycles
  localparam int TMAX = 9999;
  localparam int ALT  = 'h2AA;
  localparam int ALL  = (1 << NL) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          react = 1'b0;
  logic [6:0]    rnd = 7'd0;
  logic [NL-1:0] ledr;
  logic [15:0]   time_ms;
  logic          time_valid, early, busy;

  int n_checks = 0;
  int n_pass   = 0;

  reaction_timer #(
    .TICKS_PER_MS(TPM), .LAMP_MS(LMS), .NLAMPS(NL),
    .WAIT_BASE_MS(WB), .WAIT_STEP_MS(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .react(react), .rnd(rnd),
    .ledr(ledr), .time_ms(time_ms), .time_valid(time_valid),
    .early(early), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int   cyc;
    logic st;
    logic rc;
    int   e_ledr;
    int   e_busy;
    int   e_early;
    int   e_tms;
    int   e_tv;
  } vec_t;

  typedef struct {
    int ledr;
    int busy;
    int early;
    int tms;
    int tv;
  } exp_t;

  vec_t vt[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  nm, act, act, req, req, $time);
  endtask

  task automatic chk_all(input string tag, input int e_ledr, input int e_busy,
                         input int e_early, input int e_tms, input int e_tv);
    chk({tag, ".ledr"}, int'(ledr), e_ledr);
    chk({tag, ".busy"}, int'(busy), e_busy);
    chk({tag, ".early"}, int'(early), e_early);
    chk({tag, ".time_ms"}, int'(time_ms), e_tms);
    chk({tag, ".time_valid"}, int'(time_valid), e_tv);
  endtask

  function automatic vec_t mk(int cyc, logic st, logic rc, int e_ledr, int e_busy,
                              int e_early, int e_tms, int e_tv);
    vec_t v;
    v.cyc = cyc; v.st = st; v.rc = rc; v.e_ledr = e_ledr; v.e_busy = e_busy;
    v.e_early = e_early; v.e_tms = e_tms; v.e_tv = e_tv;
    return v;
  endfunction

  // Expected outputs t cycles after LIGHTS became visible, for a hold-off of
  // w cycles and the first react asserted in cycle x (-1 = never).
  function automatic exp_t model(int t, int w, int x);
    exp_t e;
    int t0, done_at;
    t0 = L + w;
    e.ledr = 0; e.busy = 0; e.early = 0; e.tms = 0; e.tv = 0;
    if (x >= 0 && x < t0 && t > x) begin
      e.ledr = ALT; e.early = 1;
    end else if (t < L) begin
      e.ledr = (1 << (t / (LMS * TPM) + 1)) - 1; e.busy = 1;
    end else if (t < t0) begin
      e.ledr = ALL; e.busy = 1;
    end else begin
      done_at = (x >= t0) ? x + 1 : t0 + TPM * TMAX;
      if (t >= done_at) begin
        e.tms = (done_at - t0) / TPM;
        if (e.tms > TMAX) e.tms = TMAX;
        e.tv  = (t == done_at) ? 1 : 0;
      end else begin
        e.busy = 1; e.tms = (t - t0) / TPM;
      end
    end
    return e;
  endfunction

  int   k, guard, extra_tv, w_rnd, w, x, end_t;
  logic hit;
  exp_t e;

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom); react = 1'($urandom); rnd = 7'($urandom);
      step();
      chk_all($sformatf("reset%0d", i), 0, 0, 0, 0, 0);
    end
    start = 0; react = 0;
    rst_n = 1'b1;
    step();

    // Full run, rnd=5, react 10 ms into TIMING, a start ignored while busy
    vt.push_back(mk(0,   1, 0, 'h001, 1, 0, 0, 0));
    vt.push_back(mk(7,   0, 0, 'h001, 1, 0, 0, 0));
    vt.push_back(mk(8,   0, 0, 'h003, 1, 0, 0, 0));
    vt.push_back(mk(30,  1, 0, 'h00F, 1, 0, 0, 0));
    vt.push_back(mk(71,  0, 0, 'h1FF, 1, 0, 0, 0));
    vt.push_back(mk(72,  0, 0, 'h3FF, 1, 0, 0, 0));
    vt.push_back(mk(80,  0, 0, 'h3FF, 1, 0, 0, 0));
    vt.push_back(mk(115, 0, 0, 'h3FF, 1, 0, 0, 0));
    vt.push_back(mk(116, 0, 0, 'h000, 1, 0, 0, 0));
    vt.push_back(mk(119, 0, 0, 'h000, 1, 0, 0, 0));
    vt.push_back(mk(120, 0, 0, 'h000, 1, 0, 1, 0));
    vt.push_back(mk(156, 0, 0, 'h000, 1, 0, 10, 0));
    vt.push_back(mk(157, 0, 1, 'h000, 0, 0, 10, 1));
    vt.push_back(mk(158, 0, 0, 'h000, 0, 0, 10, 0));
    vt.push_back(mk(170, 0, 0, 'h000, 0, 0, 10, 0));
    k = 0;
    for (int c = 0; c <= 170; c++) begin
      hit   = (k < vt.size()) && (vt[k].cyc == c);
      start = hit ? vt[k].st : 1'b0;
      react = hit ? vt[k].rc : 1'b0;
      rnd   = 7'd5;
      step();
      if (hit) begin
        chk_all($sformatf("run_c%0d", c), vt[k].e_ledr, vt[k].e_busy,
                vt[k].e_early, vt[k].e_tms, vt[k].e_tv);
        k++;
      end
    end
    start = 0; react = 0;

    // Restart from DONE clears the previous result
    start = 1; step(); start = 0;
    chk_all("restart", 'h001, 1, 0, 0, 0);

    // False start once ledr shows 0x007
    guard = 0;
    while (ledr != 10'h007 && guard < 40) begin step(); guard++; end
    chk("reach_007", int'(ledr), 'h007);
    react = 1; step(); react = 0;
    chk_all("false", ALT, 0, 1, 0, 0);
    extra_tv = 0;
    for (int i = 0; i < 6; i++) begin
      react = 1'($urandom); step();
      if (time_valid) extra_tv++;
    end
    react = 0;
    chk("false_no_valid", extra_tv, 0);
    chk("false_hold_early", int'(early), 1);

    // Boundary race: react on the cycle the hold-off expires (rnd=0 -> 16 cycles)
    rnd = 7'd0;
    start = 1; step(); start = 0;
    chk("race_entry_early", int'(early), 0);
    for (int t = 0; t < L + 16 - 1; t++) step();
    chk("race_prewait.ledr", int'(ledr), ALL);
    chk("race_prewait.busy", int'(busy), 1);
    react = 1; step(); react = 0;
    chk_all("race", ALT, 0, 1, 0, 0);

    // One cycle later TIMING has begun; immediate react reports 0 ms
    start = 1; step(); start = 0;
    for (int t = 0; t < L + 16; t++) step();
    chk_all("timing_entry", 0, 1, 0, 0, 0);
    react = 1; step(); react = 0;
    chk_all("react_0ms", 0, 0, 0, 0, 1);

    // Timeout: no react, count saturates at 9999
    start = 1; step(); start = 0;
    guard = 0;
    while (!time_valid && guard < L + 16 + TPM * TMAX + 20) begin step(); guard++; end
    chk_all("timeout", 0, 0, 0, TMAX, 1);
    extra_tv = 0;
    react = 1; step(); react = 0;
    for (int i = 0; i < 20; i++) begin
      if (time_valid) extra_tv++;
      step();
    end
    chk("timeout_single_pulse", extra_tv, 0);
    chk("timeout_hold", int'(time_ms), TMAX);

    // Restart from DONE, then asynchronous reset in mid-WAIT
    start = 1; step(); start = 0;
    chk_all("restart_to", 'h001, 1, 0, 0, 0);
    for (int t = 0; t < L + 5; t++) step();
    chk("midwait.ledr", int'(ledr), ALL);
    chk("midwait.busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk_all("post_rst", 0, 0, 0, 0, 0);

    // Randomized runs against the timeline model
    for (int run = 0; run < 8; run++) begin
      w_rnd = $urandom_range(0, 127);
      w     = (WB + w_rnd * WS) * TPM;
      x     = $urandom_range(0, L + w + 50);
      end_t = x + 5;
      start = 1; react = 0; rnd = 7'($urandom); step(); start = 0;
      for (int t = 0; t <= end_t; t++) begin
        e = model(t, w, x);
        chk_all($sformatf("rnd%0d_t%0d", run, t), e.ledr, e.busy, e.early, e.tms, e.tv);
        react = (t == x) || (t > x && $urandom_range(0, 1) == 1);
        rnd   = (t == L - 1) ? 7'(w_rnd) : 7'($urandom);
        start = (e.busy == 1) && ($urandom_range(0, 3) == 0);
        step();
      end
      start = 0; react = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
